simple_dp_ram_sclk: RTL and testbench
=====================================

# simple_dp_ram_sclk

Single-clock simple dual-port RAM: one write port and one registered read port on the same clock. It is the storage element behind the store-buffer FIFO (`fifo`). The FIFO drives the write port from its write pointer and the read port from its read pointer. An optional bypass returns write data when a read and a write hit the same address in the same cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: address width. Depth is 2^ADDR_WIDTH words. Must be ≥1.
- `DATA_WIDTH`, default 32: word width. Must be ≥1.
- `ENABLE_BYPASS`, default 1: 1 enables same-address write-to-read forwarding; 0 gives plain RAM read-during-write behaviour.

Ports:
- `clk`  in  1: single clock, all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `raddr`  in  ADDR_WIDTH: read address.
- `re`  in  1: read enable.
- `waddr`  in  ADDR_WIDTH: write address.
- `we`  in  1: write enable.
- `din`  in  DATA_WIDTH: write data.
- `dout`  out  DATA_WIDTH: read data, registered.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH array.
  - No reset of array contents.
  - Contents are undefined until written.
- Write: `we`=1 at an edge stores `din` into `mem[waddr]`.
- Read: `re`=1 at an edge loads `mem[raddr]` into the output register, using the array value before this edge's write.
- `re`=0: `dout` holds its previous value, whatever `we` does.
- Bypass, when ENABLE_BYPASS=1:
  - If `we`=1, `re`=1 and `waddr`==`raddr` at an edge, then after that edge `dout` = `din` sampled at that edge, not the old word.
  - Implement it as:
    - a `din_r` register, loaded from `din` whenever `re`=1;
    - a `bypass` flag, set on a same-address hit with `re`=1 and cleared on any other `re`=1 edge;
    - `dout` = `bypass` ? `din_r` : `rdata`.
  - Both registers hold while `re`=0.
- No bypass, when ENABLE_BYPASS=0: a same-address collision returns the old word.
- Read and write to different addresses are fully independent.
- Reset: `rst`=1 at an edge clears `rdata`, `din_r` and `bypass` to 0.
  - `dout`=0 from the following cycle until the first read.
  - Reset has priority over `re`.
  - Reset does not block `we`: a write during reset still updates the array.

## Timing
- Read latency is one cycle: address and `re` at edge N give data on `dout` after edge N, valid for the whole of cycle N+1.
- Write takes effect at the edge. A read of that address at a later edge returns the new data.
- Same-edge collision:
  - ENABLE_BYPASS=1: new data.
  - ENABLE_BYPASS=0: old data.
- No handshake and no back-pressure. Every `we`/`re` is accepted each cycle.
- Reset mid-operation: the output register is cleared at that edge; the array keeps its contents.
- Address wrap is the caller's concern. All addresses are in range by construction.

## Structure
- No shared package: parameters are local to the block and no typedefs are shared.
- Single module, no sub-modules.
- Bypass logic is inside a generate block selected by ENABLE_BYPASS.
- The array must infer block RAM or registers: one write process, one registered-read process.

## Test plan
- Reset: write 0xA5A5A5A5 to addr 3, then assert `rst` for 1 cycle, then release.
  - `dout`=0 after the reset edge.
  - A read of addr 3 then returns 0xA5A5A5A5: the array is not cleared.
- Basic read/write: write 0x11111111 to addr 0 and 0x22222222 to addr 255. Read addr 0, then addr 255.
  - `dout` = 0x11111111 one cycle after the first read edge.
  - `dout` = 0x22222222 one cycle after the second read edge.
- Hold: read addr 0 (0x11111111), then keep `re`=0 for 5 cycles while writing 0xDEADBEEF to addr 0.
  - `dout` stays 0x11111111 throughout.
- Bypass collision, ENABLE_BYPASS=1: addr 7 holds 0x0. At one edge: `we`=1, `re`=1, `waddr`=`raddr`=7, `din`=0xCAFEF00D.
  - `dout`=0xCAFEF00D next cycle.
  - After a subsequent `re` to addr 1 (0x11111111): `dout`=0x11111111, showing the bypass is cleared.
- Collision, ENABLE_BYPASS=0: same stimulus.
  - `dout`=0x0 (old data).
  - The next read of addr 7 returns 0xCAFEF00D.
- FIFO-style streaming: write addrs 0..255 with data = addr every cycle; read with a one-cycle lag, then wrap and overwrite.
  - Every `dout` equals the expected value one cycle after its read edge.
  - No same-cycle hazard corrupts data.

Source files
------------

// File: rtl/simple_dp_ram_sclk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Optional same-address write-to-read forwarding selected by ENABLE_BYPASS.
module simple_dp_ram_sclk #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int ENABLE_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array; contents are never reset so it can map onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_dout;

    // Write port: reset deliberately does not gate writes.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
    end

    // Registered read port: sees the array value from before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    generate
        if (ENABLE_BYPASS != 0) begin : g_bypass
            logic [DATA_WIDTH-1:0] r_din;
            logic                  r_bypass;

            // Capture write data alongside each read and flag same-address hits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_din    <= '0;
                    r_bypass <= 1'b0;
                end else if (re) begin
                    r_din    <= din;
                    r_bypass <= we && (waddr == raddr);
                end
            end

            assign w_dout = r_bypass ? r_din : r_rdata;
        end else begin : g_no_bypass
            assign w_dout = r_rdata;
        end
    endgenerate

    assign dout = w_dout;

endmodule

// File: tb/tb_simple_dp_ram_sclk.sv
// Directed bench for simple_dp_ram_sclk: drives one bypass and one
// non-bypass instance with identical stimulus and checks both outputs.
module tb_simple_dp_ram_sclk;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  raddr;
    logic        re;
    logic [7:0]  waddr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout_byp;
    logic [31:0] dout_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_dp_ram_sclk #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ENABLE_BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .raddr(raddr), .re(re),
        .waddr(waddr), .we(we), .din(din), .dout(dout_byp)
    );

    simple_dp_ram_sclk #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ENABLE_BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .re(re),
        .waddr(waddr), .we(we), .din(din), .dout(dout_nb)
    );

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [31:0] exp);
        check({tag, "_byp"}, dout_byp, exp);
        check({tag, "_nb"}, dout_nb, exp);
    endtask

    task automatic idle();
        re = 1'b0; we = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; din = '0;
        @(negedge clk);

        // Reset test: write before reset, then reset with a concurrent write.
        we = 1'b1; waddr = 8'd3; din = 32'hA5A5A5A5; tick();
        rst = 1'b1; we = 1'b1; waddr = 8'd4; din = 32'h44444444; tick();
        $display("reset edge: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("reset_clears_dout", 32'h0);
        idle(); tick();
        check_both("reset_holds_zero", 32'h0);
        re = 1'b1; raddr = 8'd3; tick();
        $display("read addr 3: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("array_kept_addr3", 32'hA5A5A5A5);
        raddr = 8'd4; tick();
        $display("read addr 4: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("write_during_reset", 32'h44444444);

        // Basic write/read, including the top address.
        idle();
        we = 1'b1; waddr = 8'd0;   din = 32'h11111111; tick();
        waddr = 8'd255; din = 32'h22222222; tick();
        waddr = 8'd1;   din = 32'h11111111; tick();
        waddr = 8'd7;   din = 32'h00000000; tick();
        idle();
        re = 1'b1; raddr = 8'd0; tick();
        $display("read addr 0: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("read_addr0", 32'h11111111);
        raddr = 8'd255; tick();
        $display("read addr 255: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("read_addr255", 32'h22222222);

        // Hold: re low for 5 cycles while overwriting the address just read.
        raddr = 8'd0; tick();
        check_both("hold_initial", 32'h11111111);
        re = 1'b0; we = 1'b1; waddr = 8'd0; din = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("hold cycle %0d: dout_byp=%h dout_nb=%h", i, dout_byp, dout_nb);
            check_both("hold_re_low", 32'h11111111);
        end

        // Same-address collision at address 7 (holds 0).
        idle();
        we = 1'b1; re = 1'b1; waddr = 8'd7; raddr = 8'd7; din = 32'hCAFEF00D; tick();
        $display("collision: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check("collision_byp_new", dout_byp, 32'hCAFEF00D);
        check("collision_nb_old", dout_nb, 32'h00000000);
        // Bypass output must hold while re is low even as din changes.
        re = 1'b0; we = 1'b1; waddr = 8'd9; din = 32'h55555555; tick();
        check("bypass_hold_byp", dout_byp, 32'hCAFEF00D);
        check("bypass_hold_nb", dout_nb, 32'h00000000);
        idle();
        re = 1'b1; raddr = 8'd1; tick();
        $display("read addr 1 after collision: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("bypass_cleared", 32'h11111111);
        raddr = 8'd7; tick();
        $display("reread addr 7: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("collision_wrote", 32'hCAFEF00D);

        // Reset has priority over a concurrent read.
        rst = 1'b1; re = 1'b1; raddr = 8'd7; tick();
        $display("reset with re: dout_byp=%h dout_nb=%h", dout_byp, dout_nb);
        check_both("reset_over_re", 32'h0);
        idle();

        // FIFO-style streaming: two passes over all addresses, one-cycle read lag.
        for (int k = 0; k < 512; k++) begin
            we = 1'b1; waddr = k[7:0]; din = k;
            re = (k > 0); raddr = 8'(k - 1);
            tick();
            if (k > 0) begin
                $display("stream k=%0d raddr=%0d dout_byp=%h dout_nb=%h", k, k - 1, dout_byp, dout_nb);
                check_both("stream", 32'(k - 1));
            end
        end
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
